// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-side controller: register map and STATUS bit layout.
package uart_pkg;

  localparam logic [1:0] UART_REG_STATUS  = 2'd0;
  localparam logic [1:0] UART_REG_DATA    = 2'd1;
  localparam logic [1:0] UART_REG_CONTROL = 2'd2;

  localparam int unsigned STATUS_RX_READY  = 0;
  localparam int unsigned STATUS_OVERRUN   = 1;
  localparam int unsigned STATUS_COUNT_LSB = 8;

endpackage

// File: rtl/rx_char_fifo.sv
// Synchronous character FIFO with combinational head output.
// A push while full is accepted only when a pop happens in the same cycle.
module rx_char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW:0]   CountFull = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    if (do_push && !do_pop)      count_d = count_q + CountOne;
    else if (!do_push && do_pop) count_d = count_q - CountOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: character FIFO, overrun tracking, STATUS/DATA/CONTROL registers.
// Defining UART_RX_IRQ_EN adds the CONTROL irq_enable bit and the rx_irq output.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_char,
  input  logic        rx_char_valid,
  input  logic [1:0]  io_address,
  input  logic        io_read_en,
  input  logic        io_write_en,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data
`ifdef UART_RX_IRQ_EN
  ,
  output logic        rx_irq
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CountOne = CW'(1);

  logic [7:0]    head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          pop_req, accept, drop;
  logic          overrun_q, overrun_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          unused_wdata;

  assign pop_req = io_read_en && (io_address == UART_REG_DATA) && !empty;
  assign accept  = rx_char_valid && (!full || pop_req);
  assign drop    = rx_char_valid && !accept;

  assign unused_wdata = ^io_write_data;

  rx_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .pop       (pop_req),
    .push_data (rx_char),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef UART_RX_IRQ_EN
  logic irq_enable_q, irq_enable_d;
  logic rx_irq_q, rx_irq_d;
  logic empty_next;

  // Occupancy after this edge, so the interrupt reflects the post-edge state.
  assign empty_next = !accept && (empty || (pop_req && (count == CountOne)));

  always_comb begin
    irq_enable_d = irq_enable_q;
    if (io_write_en && (io_address == UART_REG_CONTROL)) irq_enable_d = io_write_data[0];
    rx_irq_d = irq_enable_d && (!empty_next || overrun_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_enable_q <= 1'b0;
      rx_irq_q     <= 1'b0;
    end else begin
      irq_enable_q <= irq_enable_d;
      rx_irq_q     <= rx_irq_d;
    end
  end

  assign rx_irq = rx_irq_q;
`else
  logic unused_count_one;
  assign unused_count_one = ^CountOne;
`endif

  always_comb begin
    overrun_d = overrun_q;
    if (io_write_en && (io_address == UART_REG_STATUS) && io_write_data[STATUS_OVERRUN]) begin
      overrun_d = 1'b0;
    end
    // A drop in the same cycle as a clear must win.
    if (drop) overrun_d = 1'b1;
  end

  always_comb begin
    read_data_d = read_data_q;
    if (io_read_en) begin
      read_data_d = '0;
      case (io_address)
        UART_REG_STATUS: begin
          read_data_d[STATUS_RX_READY]              = !empty;
          read_data_d[STATUS_OVERRUN]               = overrun_q;
          read_data_d[STATUS_COUNT_LSB +: CW]       = count;
        end
        UART_REG_DATA: begin
          if (!empty) read_data_d[7:0] = head;
        end
`ifdef UART_RX_IRQ_EN
        UART_REG_CONTROL: read_data_d[0] = irq_enable_q;
`endif
        default: read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      read_data_q <= '0;
    end else begin
      overrun_q   <= overrun_d;
      read_data_q <= read_data_d;
    end
  end

  assign io_read_data = read_data_q;

endmodule
